dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_picker.sv | 33 +++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin priority search starting at i_ptr.
// Produces a one-hot grant, the binary winner id and an any-request flag.
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDW-1:0]   o_id,
    output logic             o_any
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = IDW'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among requesters.
// Each accepted request takes IDLE -> ACCESS -> RESP, one cycle each.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_read_en,
    output logic                    mem_write_en,
    input  logic [DATA_W-1:0]       mem_read_data,
    output logic                    busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mem_re;
    logic                r_mem_we;
    logic [N_REQ-1:0]    r_resp_valid;
    logic [DATA_W-1:0]   r_rdata;

    logic [N_REQ-1:0]    w_grant;
    logic [IDW-1:0]      w_id;
    logic                w_any;
    logic [IDW-1:0]      w_ptr_nxt;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    assign w_ptr_nxt = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= '0;
            r_rdata      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_resp_valid <= '0;
                    if (w_any) begin
                        r_id     <= w_id;
                        r_we     <= req_we[w_id];
                        r_addr   <= req_addr[w_id*ADDR_W +: ADDR_W];
                        r_wdata  <= req_wdata[w_id*DATA_W +: DATA_W];
                        r_mem_we <= req_we[w_id];
                        r_mem_re <= !req_we[w_id];
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_we     <= 1'b0;
                    r_mem_re     <= 1'b0;
                    // Reads sample the combinational memory output here.
                    if (!r_we) r_rdata <= mem_read_data;
                    r_resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << r_id;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= '0;
                    r_ptr        <= w_ptr_nxt;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == IDLE) ? w_grant : '0;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_rdata;
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_read_en    = r_mem_re;
    assign mem_write_en   = r_mem_we;
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 memory.
// Inputs change on falling edges; outputs are checked there too.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_address;
    logic [15:0] mem_write_data;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [15:0] mem_read_data;
    logic        busy;

    logic [15:0] mem [256];
    int total;
    int bad;

    dmem_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int r, input logic we, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
        logic [1:0] oh;
        oh = 2'b01 << r;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*8 +: 8] = a;
        req_wdata[r*16 +: 16] = d;
        #1 chk("x_ready", 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        @(negedge clk);
        chk("x_acc_en", {30'd0, mem_write_en, mem_read_en}, {30'd0, we, !we});
        chk("x_acc_addr", 32'(mem_address), 32'(a));
        chk("x_acc_busy", 32'({busy, req_ready}), 32'(3'b100));
        if (we) chk("x_acc_wdata", 32'(mem_write_data), 32'(d));
        @(negedge clk);
        chk("x_resp_v", 32'(resp_valid), 32'(oh));
        chk("x_resp_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
        chk("x_rdata", 32'(resp_rdata), 32'(exp));
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {25'd0, busy, req_ready, resp_valid, mem_read_en,
            mem_write_en}, 32'd0);
        chk("rst_mem", {8'd0, mem_address, mem_write_data}, 32'd0);
        chk("rst_rdata", 32'(resp_rdata), 32'd0);

        // Both requesters held: grants alternate 0,1,0,1 from rr_ptr=0.
        req_valid = 2'b11;
        req_we = 2'b10;
        req_addr = {8'h02, 8'h01};
        req_wdata = {16'h1234, 16'h0000};
        for (int g = 0; g < 4; g++) begin
            #1 chk("sim_ready", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("sim_we", 32'(mem_write_en), (g % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            chk("sim_resp", 32'(resp_valid), (g % 2 == 0) ? 32'd1 : 32'd2);
            chk("sim_rdata", 32'(resp_rdata), 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1 chk("sim_drop", 32'(req_ready), 32'd0);

        xact(0, 1'b1, 8'h10, 16'hBEEF, 16'h0000);
        xact(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
        xact(1, 1'b1, 8'hFF, 16'hA5A5, 16'hBEEF);
        xact(0, 1'b0, 8'hFF, 16'h0000, 16'hA5A5);
        xact(1, 1'b1, 8'h00, 16'h0001, 16'hA5A5);
        xact(0, 1'b0, 8'h00, 16'h0000, 16'h0001);

        // Requester 0 keeps a read pending: one response every 3 cycles.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        req_addr[7:0] = 8'h10;
        for (int j = 0; j < 9; j++) begin
            #1;
            chk("b2b_ready", 32'(req_ready), (j % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_resp", 32'(resp_valid), (j % 3 == 2) ? 32'd1 : 32'd0);
            if (j % 3 == 2) chk("b2b_rdata", 32'(resp_rdata), 32'hBEEF);
            @(negedge clk);
        end
        req_valid = 2'b00;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle", {25'd0, busy, req_ready, resp_valid, mem_read_en,
                mem_write_en}, 32'd0);
        end

        xact(0, 1'b1, 8'h20, 16'h5555, 16'hBEEF);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        req_addr[7:0] = 8'h20;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mid_acc", {30'd0, busy, mem_read_en}, 32'd3);
        rst = 1'b1;
        #1 chk("mid_rst", {27'd0, busy, resp_valid, mem_read_en,
            mem_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_nresp", {29'd0, busy, resp_valid}, 32'd0);
        @(negedge clk);
        chk("mid_nresp2", {29'd0, busy, resp_valid}, 32'd0);
        xact(0, 1'b0, 8'h20, 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
